// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encoding, BCD digit limits and digit type for the time-of-day blocks.
package clock_pkg;
    typedef logic [3:0] bcd_t;
    localparam logic [1:0] MODE_SET             = 2'b01;
    localparam bcd_t       SEC_TENS_MAX         = 4'd5;
    localparam bcd_t       UNITS_MAX            = 4'd9;
    localparam bcd_t       HOUR_TENS_MAX        = 4'd2;
    localparam bcd_t       HOUR_UNITS_MAX_AT_20 = 4'd3;
endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit that loads, or counts 0..MAX and wraps with a carry.
// Ports: clk, rst_n (sync, active-low), load/load_val (load wins over inc),
//        inc (advance one step), digit (current value), carry (inc while at MAX).
module bcd_digit_counter
    import clock_pkg::*;
#(
    parameter bcd_t MAX = UNITS_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  bcd_t load_val,
    input  logic inc,
    output bcd_t digit,
    output logic carry
);
    assign carry = inc && digit == MAX;

    always_ff @(posedge clk) begin
        if (!rst_n)
            digit <= '0;
        else if (load)
            digit <= load_val;
        else if (inc)
            digit <= (digit == MAX) ? '0 : digit + 4'd1;
    end
endmodule

// File: rtl/timekeeper_core.sv
// timekeeper_core: 24-hour BCD time-of-day counter loaded from the set-time block on leaving SET.
// Ports: clk, rst_n (sync, active-low), set_mode (01 = SET, else RUN),
//        set_hour1..set_sec2 (BCD load value), hour1..sec2 (running time),
//        tick_1hz / day_wrap / load_err (registered one-cycle strobes).
module timekeeper_core
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] set_mode,
    input  bcd_t       set_hour1,
    input  bcd_t       set_hour2,
    input  bcd_t       set_min1,
    input  bcd_t       set_min2,
    input  bcd_t       set_sec1,
    input  bcd_t       set_sec2,
    output bcd_t       hour1,
    output bcd_t       hour2,
    output bcd_t       min1,
    output bcd_t       min2,
    output bcd_t       sec1,
    output bcd_t       sec2,
    output logic       tick_1hz,
    output logic       day_wrap,
    output logic       load_err
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc;
    logic [1:0]    prev_mode;
    logic          in_set, exit_set, load_ok, load, wrap, hour_max;
    logic          c_s2, c_s1, c_m2, c_m1;

    always_comb begin
        in_set   = set_mode == MODE_SET;
        exit_set = prev_mode == MODE_SET && !in_set;
        load_ok  = set_hour1 < HOUR_TENS_MAX ||
                   (set_hour1 == HOUR_TENS_MAX && set_hour2 <= HOUR_UNITS_MAX_AT_20);
        load     = exit_set && load_ok;
        // A load cycle always restarts the second, so it can never also tick.
        wrap     = !in_set && !exit_set && presc == PW'(TICK_DIV - 1);
        hour_max = hour1 == HOUR_TENS_MAX && hour2 == HOUR_UNITS_MAX_AT_20;
    end

    bcd_digit_counter #(.MAX(UNITS_MAX)) u_sec2 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(set_sec2), .inc(wrap),
        .digit(sec2), .carry(c_s2));
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec1 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(set_sec1), .inc(c_s2),
        .digit(sec1), .carry(c_s1));
    bcd_digit_counter #(.MAX(UNITS_MAX)) u_min2 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(set_min2), .inc(c_s1),
        .digit(min2), .carry(c_m2));
    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_min1 (
        .clk(clk), .rst_n(rst_n), .load(load), .load_val(set_min1), .inc(c_m2),
        .digit(min1), .carry(c_m1));

    // Hours are kept as a pair because 23 wraps to 00 rather than to 24.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc     <= '0;
            prev_mode <= 2'b00;
            hour1     <= '0;
            hour2     <= '0;
            tick_1hz  <= 1'b0;
            day_wrap  <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            prev_mode <= set_mode;
            presc     <= (in_set || exit_set || wrap) ? '0 : presc + 1'b1;
            tick_1hz  <= wrap;
            day_wrap  <= c_m1 && hour_max;
            load_err  <= exit_set && !load_ok;
            if (load) begin
                hour1 <= set_hour1;
                hour2 <= set_hour2;
            end else if (c_m1) begin
                hour1 <= hour_max ? '0 : (hour2 == UNITS_MAX) ? hour1 + 4'd1 : hour1;
                hour2 <= (hour_max || hour2 == UNITS_MAX) ? '0 : hour2 + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_timekeeper_core.sv
// tb_timekeeper_core: directed and randomized checks of timekeeper_core against a seconds-of-day model.
module tb_timekeeper_core;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] set_mode;
    logic [3:0] set_hour1, set_hour2, set_min1, set_min2, set_sec1, set_sec2;
    logic [3:0] hour1, hour2, min1, min2, sec1, sec2;
    logic       tick_1hz, day_wrap, load_err;

    int errors = 0;
    int checks = 0;

    int         m_tod, m_pre;
    logic [1:0] m_pm;
    logic       m_tick, m_dw, m_err;

    always #5 clk = ~clk;

    timekeeper_core #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .set_mode(set_mode),
        .set_hour1(set_hour1), .set_hour2(set_hour2),
        .set_min1(set_min1), .set_min2(set_min2),
        .set_sec1(set_sec1), .set_sec2(set_sec2),
        .hour1(hour1), .hour2(hour2), .min1(min1), .min2(min2),
        .sec1(sec1), .sec2(sec2),
        .tick_1hz(tick_1hz), .day_wrap(day_wrap), .load_err(load_err));

    function automatic logic [23:0] digits_of(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [23:0] dut_digits();
        return {hour1, hour2, min1, min2, sec1, sec2};
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: time is an integer second of the day; one tick every 4 RUN cycles.
    task automatic model_edge();
        int hh;
        logic ex;
        m_tick = 1'b0;
        m_dw   = 1'b0;
        m_err  = 1'b0;
        if (!rst_n) begin
            m_tod = 0;
            m_pre = 0;
            m_pm  = 2'b00;
        end else begin
            ex = (m_pm == 2'b01) && (set_mode != 2'b01);
            if (ex) begin
                m_pre = 0;
                hh = set_hour1 * 10 + set_hour2;
                if (hh <= 23)
                    m_tod = hh * 3600 + (set_min1 * 10 + set_min2) * 60 + set_sec1 * 10 + set_sec2;
                else
                    m_err = 1'b1;
            end else if (set_mode == 2'b01) begin
                m_pre = 0;
            end else if (m_pre == 3) begin
                m_pre  = 0;
                m_tick = 1'b1;
                m_dw   = (m_tod == 86399);
                m_tod  = (m_tod + 1) % 86400;
            end else begin
                m_pre++;
            end
            m_pm = set_mode;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("digits", dut_digits(), digits_of(m_tod));
        chk("tick_1hz", {23'b0, tick_1hz}, {23'b0, m_tick});
        chk("day_wrap", {23'b0, day_wrap}, {23'b0, m_dw});
        chk("load_err", {23'b0, load_err}, {23'b0, m_err});
    endtask

    task automatic set_in(input int h, input int m, input int s);
        set_hour1 = 4'(h / 10);
        set_hour2 = 4'(h % 10);
        set_min1  = 4'(m / 10);
        set_min2  = 4'(m % 10);
        set_sec1  = 4'(s / 10);
        set_sec2  = 4'(s % 10);
    endtask

    task automatic load_time(input int h, input int m, input int s);
        set_mode = 2'b01;
        set_in(h, m, s);
        step();
        step();
        set_mode = 2'b00;
        step();
    endtask

    initial begin
        rst_n    = 1'b0;
        set_mode = 2'b00;
        set_in(0, 0, 0);
        step();
        step();
        chk("reset_digits", dut_digits(), 24'h000000);
        chk("reset_strobes", {21'b0, tick_1hz, day_wrap, load_err}, 24'h0);

        rst_n = 1'b1;
        repeat (3) step();
        chk("no_early_tick", {23'b0, tick_1hz}, 24'h0);
        step();
        chk("first_tick", {23'b0, tick_1hz}, 24'h1);
        chk("first_second", dut_digits(), 24'h000001);

        load_time(12, 34, 56);
        chk("load_123456", dut_digits(), 24'h123456);
        chk("load_no_tick", {23'b0, tick_1hz}, 24'h0);
        repeat (3) step();
        step();
        chk("after_load_tick", dut_digits(), 24'h123457);

        load_time(23, 59, 59);
        repeat (3) step();
        step();
        chk("midnight_digits", dut_digits(), 24'h000000);
        chk("midnight_strobes", {22'b0, tick_1hz, day_wrap}, 24'h3);
        step();
        chk("day_wrap_one_cycle", {23'b0, day_wrap}, 24'h0);

        load_time(9, 59, 59);
        repeat (4) step();
        chk("hour_09_10", dut_digits(), 24'h100000);
        chk("no_wrap_10", {23'b0, day_wrap}, 24'h0);

        load_time(19, 59, 59);
        repeat (4) step();
        chk("hour_19_20", dut_digits(), 24'h200000);

        load_time(5, 0, 0);
        set_mode = 2'b01;
        set_in(29, 0, 0);
        step();
        set_mode = 2'b00;
        step();
        chk("bad_load_err", {23'b0, load_err}, 24'h1);
        chk("bad_load_hold", dut_digits(), 24'h050000);
        step();
        chk("bad_load_err_once", {23'b0, load_err}, 24'h0);
        step();
        step();
        step();
        chk("bad_load_tick", dut_digits(), 24'h050001);

        load_time(0, 0, 0);
        set_mode = 2'b10;
        step();
        set_mode = 2'b11;
        step();
        set_mode = 2'b00;
        step();
        rst_n = 1'b0;
        step();
        chk("rst_mid_run", dut_digits(), 24'h000000);
        chk("rst_mid_run_tick", {23'b0, tick_1hz}, 24'h0);
        rst_n = 1'b1;

        for (int seg = 0; seg < 150; seg++) begin
            int r, len;
            r   = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 8));
            set_mode = (r < 3) ? 2'b01 : (r < 7) ? 2'b00 : (r < 9) ? 2'b10 : 2'b11;
            for (int k = 0; k < len; k++) begin
                rst_n = ($urandom_range(0, 79) != 0);
                set_hour1 = 4'($urandom_range(0, 2));
                set_hour2 = 4'($urandom_range(0, 9));
                set_min1  = 4'($urandom_range(0, 5));
                set_min2  = 4'($urandom_range(0, 9));
                set_sec1  = 4'($urandom_range(0, 5));
                set_sec2  = 4'($urandom_range(0, 9));
                if ($urandom_range(0, 1) == 1) begin
                    set_min1 = 4'd5;
                    set_min2 = 4'd9;
                    set_sec1 = 4'd5;
                end
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/timekeeper_core.md
Name: timekeeper_core

Overview:
- Running time-of-day counter on the consumer side of the time-set interface.
- Takes the six BCD digits produced by the set-time block and loads them when the user leaves set mode.
- Advances HH:MM:SS once per second from a clock-derived prescaler in 24-hour format.
- Drives the running digits to the display and alarm logic, plus 1 Hz and midnight strobes.

Parameters:
- TICK_DIV, 100000000: clk cycles per second. Must be >= 2. Benches use 4.

Ports:
- clk  in  1  system clock, the single clock of the block
- rst_n  in  1  synchronous active-low reset
- set_mode  in  2  mode select; 2'b01 = SET (time being edited), any other value = RUN
- set_hour1  in  4  BCD hour tens from set-time block (0-2)
- set_hour2  in  4  BCD hour units from set-time block (0-9)
- set_min1  in  4  BCD minute tens (0-5)
- set_min2  in  4  BCD minute units (0-9)
- set_sec1  in  4  BCD second tens (0-5)
- set_sec2  in  4  BCD second units (0-9)
- hour1, hour2, min1, min2, sec1, sec2  out  4 each  running time digits, same digit order as inputs
- tick_1hz  out  1  one-cycle pulse when the seconds advance
- day_wrap  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 transition
- load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (rst_n = 0 at posedge clk):
  - all digit outputs 0; prescaler 0; tick_1hz, day_wrap, load_err all 0.
  - prev_mode register reset to 2'b00.
- prev_mode registers set_mode every cycle.
- exit_set = (prev_mode == 2'b01) && (set_mode != 2'b01).
- Modes: SET (set_mode == 2'b01) and RUN (otherwise), decoded combinationally from set_mode.
- SET:
  - digits hold their value; prescaler held at 0; tick_1hz = 0; day_wrap = 0.
- exit_set cycle, with valid load (set_hour1 < 2, or set_hour1 == 2 and set_hour2 <= 3):
  - all six digits take the set_* values on that edge.
  - prescaler cleared to 0.
  - no tick in that cycle.
- exit_set cycle, with invalid load (hour > 23, e.g. 2,9):
  - digits keep their previous value; prescaler cleared; load_err pulses.
  - Minutes and seconds are not range-checked; upstream guarantees 0-5 / 0-9.
- RUN, no exit_set:
  - prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - In the cycle where it wraps, tick_1hz = 1 and the time advances by one second on that same edge.
  - First tick after a load therefore comes TICK_DIV cycles after the exit_set edge.
- Advance (BCD ripple, all on one edge):
  - sec2 9 -> 0, carry to sec1; sec1 5 -> 0, carry to min2.
  - min2 9 -> 0, carry to min1; min1 5 -> 0, carry to hour.
  - hour: units increment, except 09 -> 10, 19 -> 20, 23 -> 00.
  - 23:59:59 -> 00:00:00 also pulses day_wrap in the same cycle as tick_1hz.
- Outputs tick_1hz, day_wrap and load_err are registered; they are high for exactly one cycle.
- Precedence: reset > exit_set load > SET hold > RUN tick. An exit_set that coincides with a prescaler wrap loads and suppresses the tick.
- Re-entering SET mid-second discards the partial prescaler count.
- Mode changes between non-SET values (00 / 10 / 11) have no effect on counting.

Decomposition:
- Package clock_pkg:
  - MODE_SET = 2'b01.
  - BCD limits SEC_TENS_MAX = 5, UNITS_MAX = 9, HOUR_TENS_MAX = 2, HOUR_UNITS_MAX_AT_20 = 3.
  - a 4-bit bcd_t typedef.
- Sub-module bcd_digit_counter:
  - parameter MAX; inputs clk, rst_n, load, load_val, inc.
  - outputs digit and carry, where carry = inc && digit == MAX.
  - Used for the seconds and minutes digits.
- Hour pair logic stays in timekeeper_core because of the 23 -> 00 coupling.

Test Plan (TICK_DIV = 4):
- Reset with set_mode = 00 -> all digits 0. First tick_1hz 4 cycles after reset release, time becomes 00:00:01.
- Hold SET, present 12:34:56, drop set_mode to 00 -> digits 12:34:56 on the exit edge, no tick for 4 cycles, then 12:34:57.
- Load 23:59:59, run 4 cycles -> 00:00:00 with tick_1hz and day_wrap both high for the same single cycle.
- Load 09:59:59 then 19:59:59 -> advances to 10:00:00 and 20:00:00 respectively. No day_wrap.
- Running 05:00:00, enter SET presenting 29:00:00, exit -> load_err pulses once, digits still 05:00:00, next tick after 4 cycles gives 05:00:01.
- Assert rst_n = 0 during RUN with prescaler at 3 -> next cycle digits 0, no tick. Exit_set landing on a prescaler-wrap cycle -> load value taken, tick_1hz stays 0.
